// File: rtl/dsd_defs.sv
// Shared definitions for the serial datapath blocks: FSM state encodings and
// negation mode constants.
package dsd_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_TWOS = 1'b0;
  localparam logic MODE_ONES = 1'b1;

endpackage

// File: rtl/serial_neg_cell.sv
// One-bit serial negation cell: copy bits until the first one has passed,
// invert afterwards (two's complement), or invert every bit (one's complement).
module serial_neg_cell
  import dsd_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic b,
  input  logic mode,
  input  logic en,
  input  logic clear,
  output logic r
);

  logic seen_one;

  // Remember whether a one has already passed through this operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one <= 1'b0;
    end else if (clear) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= seen_one | b;
    end
  end

  // Per-bit negation rule.
  always_comb begin
    r = b;
    if (mode == MODE_ONES || seen_one) begin
      r = ~b;
    end
  end

endmodule

// File: rtl/twos_comp_serial.sv
// Bit-serial two's/one's complement negator with valid/ready handshakes on
// operand and result. One operand in flight; WIDTH cycles of shifting.
module twos_comp_serial
  import dsd_defs::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] next_res;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             r;
  logic             accept;
  logic             shift_en;
  logic             last;

  assign accept   = (state == ST_IDLE) && in_valid;
  assign shift_en = (state == ST_SHIFT);
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  // Result bits enter from the MSB side; res keeps only the upper WIDTH-1
  // partial bits since the final bit completes the word directly.
  assign next_res = {r, res};

  serial_neg_cell u_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (sr[0]),
    .mode  (mode_q),
    .en    (shift_en),
    .clear (accept),
    .r     (r)
  );

  // Handshake FSM, shift/result registers and registered result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sr        <= '0;
      res       <= '0;
      cnt       <= '0;
      mode_q    <= MODE_TWOS;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      OUT       <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sr       <= A;
            mode_q   <= mode;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr  <= sr >> 1;
          res <= next_res[WIDTH-1:1];
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            OUT       <= next_res;
            // Negation is a bijection, so in two's mode only the most
            // negative operand maps onto itself.
            ovf       <= (mode_q == MODE_TWOS) && (next_res == MOST_NEG);
            zero      <= (next_res == '0);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/twos_comp_serial.md
Name: twos_comp_serial

Overview:
Parametrised, bit-serial successor to the 4-bit combinational two's-complement block.
- Accepts a WIDTH-bit operand over a valid/ready handshake.
- Negates it LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule. A mode input selects one's complement instead.
- Returns the full word, an overflow flag and a zero flag over a second valid/ready handshake.
- Intended as the area-minimal negation stage ahead of serial adders and subtractors in the datapath labs.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept an operand
- A  input  WIDTH  operand, sampled on accept
- mode  input  1  0 = two's complement, 1 = one's complement; sampled on accept
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- OUT  output  WIDTH  result word
- ovf  output  1  two's-complement overflow (operand was the most negative value)
- zero  output  1  OUT is all zeros
- busy  output  1  FSM is not IDLE

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; in_ready=1; out_valid=0; OUT=0; ovf=0; zero=0; busy=0.
  - Shift register, counter, seen_one and mode latch are cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch A into shift register sr and mode into mode_q; cnt=0; seen_one=0; go to SHIFT.
  - in_valid without acceptance has no effect. A and mode are not sampled at any other time.
- SHIFT:
  - in_ready=0; busy=1.
  - Each cycle, b = sr[0]. Result bit r = mode_q ? ~b : (seen_one ? ~b : b).
  - r shifts into the result register from the MSB side. sr shifts right. seen_one |= b. cnt++.
  - When cnt == WIDTH-1 at an edge, that edge processes the final bit and moves to DONE.
  - Exactly WIDTH cycles are spent in SHIFT.
- DONE:
  - out_valid=1. OUT, ovf and zero are stable and held until out_ready=1 at an edge.
  - On that edge, go to IDLE: out_valid=0, in_ready=1.
  - OUT holds its last value after the handshake; it is not cleared.
- Latency:
  - Operand accepted at edge k gives out_valid=1 after edge k+WIDTH.
  - Minimum accept-to-accept interval is WIDTH+2 cycles, with out_ready tied high.
  - No pipelining: one operand in flight.
- ovf:
  - ovf=1 iff mode_q=0 and the operand is 1 followed by WIDTH-1 zeros. In that case OUT equals the operand.
  - ovf is always 0 in mode 1.
- zero:
  - Two's-complement mode: zero=1 iff the operand is 0.
  - One's-complement mode: zero=1 iff the operand is all ones.
- Arithmetic: result is modulo 2^WIDTH, with no sign extension.
- Reset mid-operation, in SHIFT or DONE: immediate return to reset state. The partial result is discarded and nothing is emitted.
- Back-pressure: out_ready may stay low indefinitely in DONE with no loss. in_valid asserted during SHIFT or DONE is ignored; in_ready=0 there.

Decomposition:
- Shared package/header (dsd_defs):
  - State encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Mode constants MODE_TWOS=1'b0, MODE_ONES=1'b1.
- One natural sub-module, serial_neg_cell:
  - Holds the seen_one flop and the per-bit rule (inputs b, mode, en, clear; output r).
  - Reusable by later serial subtractors.
- Top level holds the FSM, counter, shift and result registers, and flag logic.

Test Plan:
- WIDTH=4, mode=0, A=4'b0011, out_ready=1 -> OUT=4'b1101, ovf=0, zero=0, out_valid rises exactly 4 cycles after accept.
- WIDTH=4, mode=0, A=4'b1000 -> OUT=4'b1000, ovf=1. Then A=4'b0000 -> OUT=4'b0000, zero=1, ovf=0.
- WIDTH=4, mode=1, A=4'b0011 -> OUT=4'b1100. Then A=4'b1111 -> OUT=4'b0000, zero=1, ovf=0.
- Back-pressure: WIDTH=4, A=4'b0101, out_ready low for 10 cycles -> out_valid and OUT=4'b1011 held throughout, in_ready=0, a second in_valid is ignored. Then out_ready=1 -> IDLE, and the next operand is accepted.
- Reset mid-op: drop rst_n two cycles after accepting A=4'b0110 -> all outputs at reset values in the same cycle, no out_valid after release. The next operand A=4'b0110 -> OUT=4'b1010.
- WIDTH=8, mode=0, A=8'h01 -> OUT=8'hFF after 8 cycles. Back-to-back A=8'h80 -> OUT=8'h80, ovf=1. Accept-to-accept interval is 10 cycles.
